// File: rtl/axi_mst_arbiter.sv
// rtl/axi_mst_arbiter.sv - merges NUM_MST single-beat AXI masters onto one AXI4 master port
// Independent read and write arbiters; the downstream id carries the granted master index.
module axi_mst_arbiter #(
  parameter int NUM_MST  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 4,
  parameter int ARB_MODE = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_MST-1:0]           up_ar_valid_i,
  output logic [NUM_MST-1:0]           up_ar_ready_o,
  input  logic [NUM_MST*ADDR_W-1:0]    up_ar_addr_i,
  input  logic [NUM_MST*3-1:0]         up_ar_size_i,
  output logic [NUM_MST-1:0]           up_r_valid_o,
  input  logic [NUM_MST-1:0]           up_r_ready_i,
  output logic [DATA_W-1:0]            up_r_data_o,
  output logic [1:0]                   up_r_resp_o,
  input  logic [NUM_MST-1:0]           up_aw_valid_i,
  output logic [NUM_MST-1:0]           up_aw_ready_o,
  input  logic [NUM_MST*ADDR_W-1:0]    up_aw_addr_i,
  input  logic [NUM_MST*3-1:0]         up_aw_size_i,
  input  logic [NUM_MST-1:0]           up_w_valid_i,
  output logic [NUM_MST-1:0]           up_w_ready_o,
  input  logic [NUM_MST*DATA_W-1:0]    up_w_data_i,
  input  logic [NUM_MST*DATA_W/8-1:0]  up_w_strb_i,
  output logic [NUM_MST-1:0]           up_b_valid_o,
  input  logic [NUM_MST-1:0]           up_b_ready_i,
  output logic [1:0]                   up_b_resp_o,
  output logic                         io_master_arvalid,
  output logic [ADDR_W-1:0]            io_master_araddr,
  output logic [ID_W-1:0]              io_master_arid,
  output logic [7:0]                   io_master_arlen,
  output logic [2:0]                   io_master_arsize,
  output logic [1:0]                   io_master_arburst,
  input  logic                         io_master_arready,
  input  logic                         io_master_rvalid,
  input  logic [1:0]                   io_master_rresp,
  input  logic [DATA_W-1:0]            io_master_rdata,
  input  logic                         io_master_rlast,
  input  logic [ID_W-1:0]              io_master_rid,
  output logic                         io_master_rready,
  output logic                         io_master_awvalid,
  output logic [ADDR_W-1:0]            io_master_awaddr,
  output logic [ID_W-1:0]              io_master_awid,
  output logic [7:0]                   io_master_awlen,
  output logic [2:0]                   io_master_awsize,
  output logic [1:0]                   io_master_awburst,
  input  logic                         io_master_awready,
  output logic                         io_master_wvalid,
  output logic [DATA_W-1:0]            io_master_wdata,
  output logic [DATA_W/8-1:0]          io_master_wstrb,
  output logic                         io_master_wlast,
  input  logic                         io_master_wready,
  input  logic                         io_master_bvalid,
  input  logic [1:0]                   io_master_bresp,
  input  logic [ID_W-1:0]              io_master_bid,
  output logic                         io_master_bready,
  output logic                         err_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;

  r_state_t           r_state;
  w_state_t           w_state;
  logic [IDX_W-1:0]   r_gnt, r_ptr, w_gnt, w_ptr;
  logic               aw_done, w_done;
  logic [NUM_MST-1:0] w_req, r_sel, w_sel;
  logic [IDX_W-1:0]   ar_pick, w_pick;
  logic               r_bad, b_bad, r_hs, b_hs, aw_hs, w_hs, err_set;

  // Round-robin takes the first requester above ptr, else wraps to the lowest one;
  // fixed priority always falls through to the lowest requester.
  function automatic logic [IDX_W-1:0] arb_pick(input logic [NUM_MST-1:0] req,
                                                input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] sel;
    logic             hit;
    sel = '0;
    hit = 1'b0;
    if (ARB_MODE != 0) begin
      for (int i = NUM_MST - 1; i >= 0; i--) begin
        if (req[i] && (i > int'(ptr))) begin
          sel = IDX_W'(i);
          hit = 1'b1;
        end
      end
    end
    if (!hit) begin
      for (int i = NUM_MST - 1; i >= 0; i--) begin
        if (req[i]) sel = IDX_W'(i);
      end
    end
    return sel;
  endfunction

  assign w_req   = up_aw_valid_i & up_w_valid_i;
  assign ar_pick = arb_pick(up_ar_valid_i, r_ptr);
  assign w_pick  = arb_pick(w_req, w_ptr);
  assign r_sel   = NUM_MST'(1) << r_gnt;
  assign w_sel   = NUM_MST'(1) << w_gnt;

  assign io_master_arlen   = 8'd0;
  assign io_master_arburst = 2'b01;
  assign io_master_awlen   = 8'd0;
  assign io_master_awburst = 2'b01;
  assign io_master_wlast   = 1'b1;

  assign r_bad = (io_master_rid != ID_W'(r_gnt)) || !io_master_rlast;
  assign b_bad = (io_master_bid != ID_W'(w_gnt));

  assign io_master_rready = (r_state == R_DATA) && up_r_ready_i[r_gnt];
  assign io_master_bready = (w_state == W_RESP) && up_b_ready_i[w_gnt];
  assign r_hs  = io_master_rvalid && io_master_rready;
  assign b_hs  = io_master_bvalid && io_master_bready;
  assign aw_hs = io_master_awvalid && io_master_awready;
  assign w_hs  = io_master_wvalid && io_master_wready;

  assign up_ar_ready_o = (r_state == R_ADDR && io_master_arready) ? r_sel : '0;
  assign up_r_valid_o  = (r_state == R_DATA && io_master_rvalid) ? r_sel : '0;
  assign up_r_data_o   = (r_state == R_DATA) ? io_master_rdata : '0;
  assign up_r_resp_o   = (r_state != R_DATA) ? 2'b00 : (r_bad ? 2'b10 : io_master_rresp);

  assign up_aw_ready_o = (w_state == W_REQ && !aw_done && io_master_awready) ? w_sel : '0;
  assign up_w_ready_o  = (w_state == W_REQ && !w_done && io_master_wready) ? w_sel : '0;
  assign up_b_valid_o  = (w_state == W_RESP && io_master_bvalid) ? w_sel : '0;
  assign up_b_resp_o   = (w_state != W_RESP) ? 2'b00 : (b_bad ? 2'b10 : io_master_bresp);

  // Stray responses are never accepted (ready stays low) but still flag the error.
  assign err_set = (io_master_rvalid && ((r_state != R_DATA) || r_bad)) ||
                   (io_master_bvalid && ((w_state != W_RESP) || b_bad));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state           <= R_IDLE;
      r_gnt             <= '0;
      r_ptr             <= IDX_W'(NUM_MST - 1);
      io_master_arvalid <= 1'b0;
      io_master_araddr  <= '0;
      io_master_arid    <= '0;
      io_master_arsize  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (|up_ar_valid_i) begin
            r_gnt             <= ar_pick;
            io_master_araddr  <= up_ar_addr_i[int'(ar_pick)*ADDR_W +: ADDR_W];
            io_master_arsize  <= up_ar_size_i[int'(ar_pick)*3 +: 3];
            io_master_arid    <= ID_W'(ar_pick);
            io_master_arvalid <= 1'b1;
            r_state           <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (io_master_arready) begin
            io_master_arvalid <= 1'b0;
            r_state           <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            r_ptr   <= r_gnt;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      w_state           <= W_IDLE;
      w_gnt             <= '0;
      w_ptr             <= IDX_W'(NUM_MST - 1);
      aw_done           <= 1'b0;
      w_done            <= 1'b0;
      io_master_awvalid <= 1'b0;
      io_master_awaddr  <= '0;
      io_master_awid    <= '0;
      io_master_awsize  <= '0;
      io_master_wvalid  <= 1'b0;
      io_master_wdata   <= '0;
      io_master_wstrb   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (|w_req) begin
            w_gnt             <= w_pick;
            io_master_awaddr  <= up_aw_addr_i[int'(w_pick)*ADDR_W +: ADDR_W];
            io_master_awsize  <= up_aw_size_i[int'(w_pick)*3 +: 3];
            io_master_awid    <= ID_W'(w_pick);
            io_master_wdata   <= up_w_data_i[int'(w_pick)*DATA_W +: DATA_W];
            io_master_wstrb   <= up_w_strb_i[int'(w_pick)*STRB_W +: STRB_W];
            io_master_awvalid <= 1'b1;
            io_master_wvalid  <= 1'b1;
            aw_done           <= 1'b0;
            w_done            <= 1'b0;
            w_state           <= W_REQ;
          end
        end
        W_REQ: begin
          if (aw_hs) begin
            io_master_awvalid <= 1'b0;
            aw_done           <= 1'b1;
          end
          if (w_hs) begin
            io_master_wvalid <= 1'b0;
            w_done           <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) w_state <= W_RESP;
        end
        W_RESP: begin
          if (b_hs) begin
            w_ptr   <= w_gnt;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) err_o <= 1'b0;
    else if (err_set) err_o <= 1'b1;
  end

endmodule

// File: tb/tb_axi_mst_arbiter.sv
// tb/tb_axi_mst_arbiter.sv - directed bench for axi_mst_arbiter (round-robin and fixed-priority instances)
module tb_axi_mst_arbiter;
  localparam int N = 2, AW = 32, DW = 32, IW = 4, SW = DW / 8;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] ar_valid, r_ready, aw_valid, w_valid, b_ready;
  logic [N*AW-1:0] ar_addr, aw_addr;
  logic [N*3-1:0] ar_size, aw_size;
  logic [N*DW-1:0] w_data;
  logic [N*SW-1:0] w_strb;
  logic arready, rvalid, rlast, awready, wready, bvalid;
  logic [1:0] rresp, bresp;
  logic [DW-1:0] rdata;
  logic [IW-1:0] rid, bid;

  logic [N-1:0] ar_ready, r_valid, aw_ready, w_ready, b_valid;
  logic [DW-1:0] r_data, wdata;
  logic [1:0] r_resp, b_resp, arburst, awburst;
  logic arvalid, rready, awvalid, wvalid, wlast, bready, err;
  logic [AW-1:0] araddr, awaddr;
  logic [IW-1:0] arid, awid;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [SW-1:0] wstrb;

  logic [N-1:0] ar_ready_f, r_valid_f, aw_ready_f, w_ready_f, b_valid_f;
  logic [DW-1:0] r_data_f, wdata_f;
  logic [1:0] r_resp_f, b_resp_f, arburst_f, awburst_f;
  logic arvalid_f, rready_f, awvalid_f, wvalid_f, wlast_f, bready_f, err_f;
  logic [AW-1:0] araddr_f, awaddr_f;
  logic [IW-1:0] arid_f, awid_f;
  logic [7:0] arlen_f, awlen_f;
  logic [2:0] arsize_f, awsize_f;
  logic [SW-1:0] wstrb_f;

  axi_mst_arbiter #(.NUM_MST(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .ARB_MODE(1)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .up_ar_valid_i(ar_valid), .up_ar_ready_o(ar_ready), .up_ar_addr_i(ar_addr), .up_ar_size_i(ar_size),
    .up_r_valid_o(r_valid), .up_r_ready_i(r_ready), .up_r_data_o(r_data), .up_r_resp_o(r_resp),
    .up_aw_valid_i(aw_valid), .up_aw_ready_o(aw_ready), .up_aw_addr_i(aw_addr), .up_aw_size_i(aw_size),
    .up_w_valid_i(w_valid), .up_w_ready_o(w_ready), .up_w_data_i(w_data), .up_w_strb_i(w_strb),
    .up_b_valid_o(b_valid), .up_b_ready_i(b_ready), .up_b_resp_o(b_resp),
    .io_master_arvalid(arvalid), .io_master_araddr(araddr), .io_master_arid(arid),
    .io_master_arlen(arlen), .io_master_arsize(arsize), .io_master_arburst(arburst),
    .io_master_arready(arready), .io_master_rvalid(rvalid), .io_master_rresp(rresp),
    .io_master_rdata(rdata), .io_master_rlast(rlast), .io_master_rid(rid), .io_master_rready(rready),
    .io_master_awvalid(awvalid), .io_master_awaddr(awaddr), .io_master_awid(awid),
    .io_master_awlen(awlen), .io_master_awsize(awsize), .io_master_awburst(awburst),
    .io_master_awready(awready), .io_master_wvalid(wvalid), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast), .io_master_wready(wready),
    .io_master_bvalid(bvalid), .io_master_bresp(bresp), .io_master_bid(bid),
    .io_master_bready(bready), .err_o(err)
  );

  axi_mst_arbiter #(.NUM_MST(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .ARB_MODE(0)) dut_fix (
    .clk_i(clk), .rst_i(rst_n),
    .up_ar_valid_i(ar_valid), .up_ar_ready_o(ar_ready_f), .up_ar_addr_i(ar_addr), .up_ar_size_i(ar_size),
    .up_r_valid_o(r_valid_f), .up_r_ready_i(r_ready), .up_r_data_o(r_data_f), .up_r_resp_o(r_resp_f),
    .up_aw_valid_i(aw_valid), .up_aw_ready_o(aw_ready_f), .up_aw_addr_i(aw_addr), .up_aw_size_i(aw_size),
    .up_w_valid_i(w_valid), .up_w_ready_o(w_ready_f), .up_w_data_i(w_data), .up_w_strb_i(w_strb),
    .up_b_valid_o(b_valid_f), .up_b_ready_i(b_ready), .up_b_resp_o(b_resp_f),
    .io_master_arvalid(arvalid_f), .io_master_araddr(araddr_f), .io_master_arid(arid_f),
    .io_master_arlen(arlen_f), .io_master_arsize(arsize_f), .io_master_arburst(arburst_f),
    .io_master_arready(arready), .io_master_rvalid(rvalid), .io_master_rresp(rresp),
    .io_master_rdata(rdata), .io_master_rlast(rlast), .io_master_rid(rid), .io_master_rready(rready_f),
    .io_master_awvalid(awvalid_f), .io_master_awaddr(awaddr_f), .io_master_awid(awid_f),
    .io_master_awlen(awlen_f), .io_master_awsize(awsize_f), .io_master_awburst(awburst_f),
    .io_master_awready(awready), .io_master_wvalid(wvalid_f), .io_master_wdata(wdata_f),
    .io_master_wstrb(wstrb_f), .io_master_wlast(wlast_f), .io_master_wready(wready),
    .io_master_bvalid(bvalid), .io_master_bresp(bresp), .io_master_bid(bid),
    .io_master_bready(bready_f), .err_o(err_f)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    ar_valid = '0; aw_valid = '0; w_valid = '0;
    r_ready = '1; b_ready = '1;
    ar_addr = '0; aw_addr = '0; ar_size = '0; aw_size = '0; w_data = '0; w_strb = '0;
    arready = 0; rvalid = 0; rlast = 0; rresp = '0; rdata = '0; rid = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0; bid = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_arvalid(input string tag);
    for (int i = 0; i < 16 && !arvalid; i++) tick();
    check(tag, arvalid, 1);
  endtask

  // Accept the pending AR, then return one R beat with the given id.
  task automatic rd_finish(input logic [IW-1:0] ret_id, input logic [DW-1:0] data);
    arready = 1; tick(); arready = 0;
    rvalid = 1; rid = ret_id; rlast = 1; rresp = 2'b00; rdata = data;
    tick();
    rvalid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    tick(); tick();
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_bready", bready, 0);
    check("rst_up_readies", {ar_ready, aw_ready, w_ready}, 0);
    check("rst_up_valids", {r_valid, b_valid}, 0);
    check("rst_err", err, 0);
    check("rst_araddr_arid", {araddr, arid}, 0);
    check("rst_wdata", wdata, 0);
    rst_n = 1'b1;
    tick();

    // Stray R beat in idle: not accepted, flags error.
    rvalid = 1; rid = 0; rlast = 1;
    #1;
    check("stray_rready", rready, 0);
    check("stray_r_valid", r_valid, 0);
    tick();
    rvalid = 0;
    check("stray_err", err, 1);
    do_reset();
    check("err_cleared_by_reset", err, 0);

    // Both masters request reads continuously.
    ar_valid = 2'b11;
    ar_addr = {32'h0000_1100, 32'h0000_0100};
    for (int n = 0; n < 4; n++) begin
      wait_arvalid($sformatf("arb%0d_wait", n));
      check($sformatf("arb%0d_rr_arid", n), arid, n % 2);
      check($sformatf("arb%0d_rr_araddr", n), araddr, (n % 2) ? 32'h0000_1100 : 32'h0000_0100);
      check($sformatf("arb%0d_fix_arid", n), arid_f, 0);
      rd_finish(IW'(n % 2), 32'h0);
    end
    ar_valid = '0;
    check("arb_err", err, 0);
    tick();

    // Single read from master 1.
    ar_valid = 2'b10;
    ar_addr = {32'h8000_0010, 32'h0};
    ar_size = {3'd2, 3'd0};
    #1;
    check("rd1_arvalid_c0", arvalid, 0);
    tick();
    check("rd1_arvalid_c1", arvalid, 1);
    check("rd1_arid", arid, 1);
    check("rd1_araddr", araddr, 32'h8000_0010);
    check("rd1_arlen_burst_size", {arlen, arburst, arsize}, {8'd0, 2'b01, 3'd2});
    check("rd1_ar_ready_low", ar_ready, 2'b00);
    arready = 1;
    #1;
    check("rd1_ar_ready", ar_ready, 2'b10);
    tick();
    arready = 0; ar_valid = 0;
    check("rd1_arvalid_drop", arvalid, 0);
    rvalid = 1; rid = 1; rlast = 1; rresp = 2'b00; rdata = 32'hDEAD_BEEF;
    #1;
    check("rd1_r_valid", r_valid, 2'b10);
    check("rd1_r_data", r_data, 32'hDEAD_BEEF);
    check("rd1_r_resp", r_resp, 2'b00);
    check("rd1_rready", rready, 1);
    tick();
    rvalid = 0;
    check("rd1_err", err, 0);
    check("rd1_rready_idle", rready, 0);

    // Write from master 1, awready three cycles ahead of wready.
    aw_valid = 2'b10; w_valid = 2'b10;
    aw_addr = {32'h1000_0020, 32'h0};
    aw_size = {3'd2, 3'd0};
    w_data = {32'hCAFE_F00D, 32'h0};
    w_strb = {4'hF, 4'h0};
    tick();
    check("wr_valids", {awvalid, wvalid}, 2'b11);
    check("wr_awid", awid, 1);
    check("wr_awaddr", awaddr, 32'h1000_0020);
    check("wr_wdata_strb_last", {wdata, wstrb, wlast}, {32'hCAFE_F00D, 4'hF, 1'b1});
    check("wr_awlen_burst", {awlen, awburst}, {8'd0, 2'b01});
    awready = 1;
    #1;
    check("wr_aw_ready", aw_ready, 2'b10);
    check("wr_w_ready_low", w_ready, 2'b00);
    tick();
    awready = 0; aw_valid = 0;
    check("wr_aw_done", {awvalid, wvalid}, 2'b01);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("wr_hold%0d", i), {wvalid, bready}, 2'b10);
    end
    wready = 1;
    #1;
    check("wr_w_ready", w_ready, 2'b10);
    check("wr_aw_ready_done", aw_ready, 2'b00);
    tick();
    wready = 0; w_valid = 0;
    check("wr_wvalid_drop", wvalid, 0);
    bvalid = 1; bid = 1; bresp = 2'b00;
    #1;
    check("wr_b_valid", b_valid, 2'b10);
    check("wr_b_resp", b_resp, 2'b00);
    check("wr_bready", bready, 1);
    tick();
    bvalid = 0;
    check("wr_idle", {awvalid, wvalid, bready, err}, 0);

    // Concurrent read (master 0) and write (master 1).
    ar_valid = 2'b01; ar_addr = {32'h0, 32'h2000_0000};
    aw_valid = 2'b10; w_valid = 2'b10;
    tick();
    check("cc_all_valid", {arvalid, awvalid, wvalid}, 3'b111);
    check("cc_ids", {arid, awid}, {4'd0, 4'd1});
    arready = 1; awready = 1; wready = 1;
    #1;
    check("cc_up_readies", {ar_ready, aw_ready, w_ready}, 6'b01_10_10);
    tick();
    arready = 0; awready = 0; wready = 0;
    ar_valid = 0; aw_valid = 0; w_valid = 0;
    rvalid = 1; rid = 0; rlast = 1; rdata = 32'h1234_5678;
    bvalid = 1; bid = 1; bresp = 2'b00;
    #1;
    check("cc_resp_valids", {r_valid, b_valid}, 4'b01_10);
    check("cc_r_data", r_data, 32'h1234_5678);
    tick();
    rvalid = 0; bvalid = 0;
    check("cc_done", {arvalid, awvalid, rready, bready, err}, 0);

    // Wrong rid for grant 0.
    ar_valid = 2'b01;
    tick();
    arready = 1; tick(); arready = 0; ar_valid = 0;
    rvalid = 1; rid = 4'd3; rlast = 1; rresp = 2'b00;
    #1;
    check("rid_err_valid", r_valid, 2'b01);
    check("rid_err_resp", r_resp, 2'b10);
    tick();
    rvalid = 0;
    check("rid_err_flag", err, 1);
    tick(); tick(); tick();
    check("rid_err_sticky", err, 1);

    // Reset in R_DATA, then a fresh read from master 1.
    ar_valid = 2'b10; ar_addr = {32'h3000_0004, 32'h0};
    tick();
    arready = 1; tick(); arready = 0; ar_valid = 0;
    rvalid = 1; rid = 1; rlast = 1; rdata = 32'hAAAA_5555;
    #1;
    check("mid_pre_r_valid", r_valid, 2'b10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_r_valid", r_valid, 2'b00);
    check("mid_rst_rready", rready, 0);
    check("mid_rst_arid_addr", {arid, araddr}, 0);
    check("mid_rst_err", err, 0);
    rvalid = 0;
    tick(); tick();
    rst_n = 1'b1;
    ar_valid = 2'b10; ar_addr = {32'h3000_0008, 32'h0};
    tick();
    check("post_arvalid", arvalid, 1);
    check("post_arid", arid, 1);
    check("post_r_valid", r_valid, 2'b00);
    rd_finish(4'd1, 32'h0);
    ar_valid = 0;
    check("post_err", err, 0);
    tick();
    check("post_idle", arvalid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
